uctl_bank_arbiter: RTL

// Shares the 4-bank buffer memory between two requesters (0: SIE packet side, 1: DMA side).

---
 rtl/uctl_bank_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uctl_bank_arbiter.sv
// uctl_bank_arbiter
// Shares the 4-bank buffer memory between two requesters (0: SIE packet
// side, 1: DMA side). Round-robin between requesters, one transaction in
// flight at a time. The bank is selected by addr[3:2]; the arbiter waits for
// that bank's ack and, on reads, its data-valid, then returns ack / read data
// / error to the granted requester. Every output is a register.
//
// Ports
//   uctl_clk, uctl_rst      core clock, synchronous active-high reset
//   uctl_mReq/mWr/mAddr/mWdata   requester side inputs, index 0 in low slice
//   uctl_mAck/mDValid/mErr       per-requester one-cycle response pulses
//   uctl_mRdata                  shared read data, valid with mDValid
//   uctl_bankReq/bankWr/bankAddr/bankWdata   one-hot bank request + payload
//   uctl_bankAck/bankDVl/bankRdata           per-bank accept, data valid, data
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; arbitrate among pending requests
// REQ     | bankReq held on the selected bank until its ack or timeout
// WAIT_DV | read accepted, waiting for the selected bank's data valid

module uctl_bank_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                  uctl_clk,
    input  logic                  uctl_rst,
    input  logic [1:0]            uctl_mReq,
    input  logic [1:0]            uctl_mWr,
    input  logic [2*ADDR_W-1:0]   uctl_mAddr,
    input  logic [2*DATA_W-1:0]   uctl_mWdata,
    output logic [1:0]            uctl_mAck,
    output logic [1:0]            uctl_mDValid,
    output logic [1:0]            uctl_mErr,
    output logic [DATA_W-1:0]     uctl_mRdata,
    output logic [3:0]            uctl_bankReq,
    output logic                  uctl_bankWr,
    output logic [ADDR_W-1:0]     uctl_bankAddr,
    output logic [DATA_W-1:0]     uctl_bankWdata,
    input  logic [3:0]            uctl_bankAck,
    input  logic [3:0]            uctl_bankDVl,
    input  logic [4*DATA_W-1:0]   uctl_bankRdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_DV = 2'd2
    } state_t;

    // The counter reads 0 in the first cycle of REQ/WAIT_DV, so the abort
    // edge is the one that sees TMO_CYC-1: exactly TMO_CYC cycles spent.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t              state_q, state_d;
    logic                rr_q, rr_d;        // preferred requester on contention
    logic                gnt_q, gnt_d;      // requester owning the transaction
    logic [1:0]          bank_q, bank_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [1:0]          mack_q, mack_d;
    logic [1:0]          mdv_q, mdv_d;
    logic [1:0]          merr_q, merr_d;
    logic [DATA_W-1:0]   mrdata_q, mrdata_d;
    logic [3:0]          breq_q, breq_d;
    logic                bwr_q, bwr_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [DATA_W-1:0]   bwdata_q, bwdata_d;

    logic                gsel;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   rdata_sel;
    logic                ack_sel;
    logic                dv_sel;

    always_comb begin
        rdata_sel = '0;
        for (int b = 0; b < 4; b++) begin
            if (bank_q == 2'(b)) begin
                rdata_sel = uctl_bankRdata[b*DATA_W +: DATA_W];
            end
        end
    end

    // Only the latched bank's handshakes matter; other banks are ignored.
    assign ack_sel = uctl_bankAck[bank_q];
    assign dv_sel  = uctl_bankDVl[bank_q];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        bank_d    = bank_q;
        cnt_d     = cnt_q + 8'd1;
        mack_d    = '0;
        mdv_d     = '0;
        merr_d    = '0;
        mrdata_d  = mrdata_q;
        breq_d    = breq_q;
        bwr_d     = bwr_q;
        baddr_d   = baddr_q;
        bwdata_d  = bwdata_q;
        gsel      = 1'b0;
        sel_addr  = uctl_mAddr[0 +: ADDR_W];
        sel_wdata = uctl_mWdata[0 +: DATA_W];

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                breq_d = '0;
                if (|uctl_mReq) begin
                    // Single requester wins outright; on contention rr_q picks.
                    gsel      = (uctl_mReq == 2'b11) ? rr_q : uctl_mReq[1];
                    sel_addr  = gsel ? uctl_mAddr[ADDR_W +: ADDR_W]
                                     : uctl_mAddr[0 +: ADDR_W];
                    sel_wdata = gsel ? uctl_mWdata[DATA_W +: DATA_W]
                                     : uctl_mWdata[0 +: DATA_W];
                    gnt_d     = gsel;
                    rr_d      = ~gsel;
                    bank_d    = sel_addr[3:2];
                    bwr_d     = uctl_mWr[gsel];
                    baddr_d   = sel_addr;
                    bwdata_d  = sel_wdata;
                    breq_d    = 4'b0001 << sel_addr[3:2];
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                // Completion is tested first so an ack on the limit cycle wins.
                if (ack_sel) begin
                    mack_d[gnt_q] = 1'b1;
                    breq_d        = '0;
                    if (bwr_q) begin
                        state_d = S_IDLE;
                    end else if (dv_sel) begin
                        mdv_d[gnt_q] = 1'b1;
                        mrdata_d     = rdata_sel;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT_DV;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    merr_d[gnt_q] = 1'b1;
                    breq_d        = '0;
                    state_d       = S_IDLE;
                end
            end

            S_WAIT_DV: begin
                breq_d = '0;
                if (dv_sel) begin
                    mdv_d[gnt_q] = 1'b1;
                    mrdata_d     = rdata_sel;
                    state_d      = S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    merr_d[gnt_q] = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                breq_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge uctl_clk) begin
        if (uctl_rst) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            bank_q   <= '0;
            cnt_q    <= '0;
            mack_q   <= '0;
            mdv_q    <= '0;
            merr_q   <= '0;
            mrdata_q <= '0;
            breq_q   <= '0;
            bwr_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            bank_q   <= bank_d;
            cnt_q    <= cnt_d;
            mack_q   <= mack_d;
            mdv_q    <= mdv_d;
            merr_q   <= merr_d;
            mrdata_q <= mrdata_d;
            breq_q   <= breq_d;
            bwr_q    <= bwr_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign uctl_mAck      = mack_q;
    assign uctl_mDValid   = mdv_q;
    assign uctl_mErr      = merr_q;
    assign uctl_mRdata    = mrdata_q;
    assign uctl_bankReq   = breq_q;
    assign uctl_bankWr    = bwr_q;
    assign uctl_bankAddr  = baddr_q;
    assign uctl_bankWdata = bwdata_q;

endmodule
